// File: rtl/alu_seq_ctrl.sv
// Round-robin sequencer for the shared 16-bit ALU: grants one of two requesters, sequences
// operand loads and execution over the bus, returns a tagged result. ALU_SEQ_STATS_EN adds op/err counters.
module alu_seq_ctrl #(
    parameter int DW     = 16,
    parameter int OPW    = 4,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_err,
    output logic [OPW-1:0] alu_op,
    output logic [2:0]     alu_en,
    output logic [DW-1:0]  bus_data,
    output logic           bus_oe,
    input  logic [DW-1:0]  alu_result
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]    op_count,
    output logic [15:0]    err_count
`endif
);

    localparam logic [OPW-1:0] OP_MIN   = OPW'(1);
    localparam logic [OPW-1:0] OP_MAX   = OPW'(9);
    localparam logic [OPW-1:0] OP_NOT   = OPW'(7);
    localparam int             CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]  CNT_INIT = CW'(SETTLE - 1);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic           last_grant_q;
    logic [OPW-1:0] op_q;
    logic [DW-1:0]  a_q, b_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rsp_id_q, rsp_err_q;
    logic [DW-1:0]  rsp_data_q;

    logic           grant_fire, grant_id, sel_legal;
    logic [OPW-1:0] sel_op;

    // Ties go to the requester that was not served last.
    assign grant_id   = req1_valid & (~req0_valid | ~last_grant_q);
    assign grant_fire = (state_q == IDLE) & (req0_valid | req1_valid) & ~rst;
    assign sel_op     = grant_id ? req1_op : req0_op;
    assign sel_legal  = (sel_op >= OP_MIN) && (sel_op <= OP_MAX);
    assign req0_ready = grant_fire & ~grant_id;
    assign req1_ready = grant_fire & grant_id;

    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_fire) state_d = sel_legal ? LOAD_A : RESP;
            LOAD_A:  state_d = (op_q == OP_NOT) ? EXEC : LOAD_B;
            LOAD_B:  state_d = EXEC;
            EXEC:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_op    = '0;
        alu_en    = 3'b000;
        bus_data  = '0;
        bus_oe    = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            LOAD_A: begin
                alu_op   = op_q;
                alu_en   = 3'b100;
                bus_data = a_q;
                bus_oe   = 1'b1;
            end
            LOAD_B: begin
                alu_op   = op_q;
                alu_en   = 3'b010;
                bus_data = b_q;
                bus_oe   = 1'b1;
            end
            EXEC: begin
                alu_op = op_q;
                alu_en = 3'b001;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Settle counter reloads whenever we are outside EXEC, so every EXEC starts fresh.
    always_comb begin
        cnt_d = CNT_INIT;
        if (state_q == EXEC && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= CNT_INIT;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (grant_fire) begin
                op_q         <= sel_op;
                a_q          <= grant_id ? req1_a : req0_a;
                b_q          <= grant_id ? req1_b : req0_b;
                last_grant_q <= grant_id;
                rsp_id_q     <= grant_id;
                rsp_err_q    <= ~sel_legal;
                rsp_data_q   <= '0;
            end else if (state_q == EXEC && cnt_q == '0) begin
                rsp_data_q <= alu_result;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] op_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_err_q) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end else begin
                if (op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
            end
        end
    end

    assign op_count  = op_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencer and arbiter for the RSC chip's 16-bit ALU.
- Accepts operation requests from two requesters (req0, req1) and arbitrates between them round-robin.
- Drives the shared data bus and the ALU enables (in1 load, in2 load, out) with the ALU opcode, in the required order.
- Captures the ALU result and returns it on a single response channel tagged with the requester ID.

Parameters:
- DW, 16, data/bus width.
- OPW, 4, opcode width.
- SETTLE, 1, cycles the ALU output enable is held before result capture (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 accepted (1-cycle pulse).
- req0_op  in  OPW  opcode.
- req0_a  in  DW  operand A.
- req0_b  in  DW  operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester index of result.
- rsp_data  out  DW  result.
- rsp_err  out  1  illegal opcode.
- alu_op  out  OPW  opcode to ALU.
- alu_en  out  3  {in1_load, in2_load, out_en}; one-hot or zero.
- bus_data  out  DW  value driven onto bus.
- bus_oe  out  1  bus drive enable.
- alu_result  in  DW  ALU output.

Behaviour:
- Reset values: all outputs 0, alu_en=000, bus_oe=0, state IDLE, last_grant=1 (so req0 wins first tie).
- Reset asserted mid-operation: abort to IDLE next edge; the pending response is dropped.
- States: IDLE, LOAD_A, LOAD_B, EXEC, RESP.
- IDLE:
  - No valid request: stay IDLE.
  - One valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - On grant: assert that reqN_ready for exactly one cycle (combinational from IDLE & grant); latch op, a, b and id; set last_grant=id.
- Legal opcodes: 0001–1001. Illegal opcodes (0000, 1010–1111) go directly to RESP with rsp_err=1 and rsp_data=0; no ALU enables are pulsed.
- LOAD_A (1 cycle): bus_oe=1, bus_data=a, alu_en=100, alu_op=op.
  - op=0111 (NOT): next state EXEC, skipping LOAD_B.
  - All other ops: next state LOAD_B.
- LOAD_B (1 cycle): bus_oe=1, bus_data=b, alu_en=010 -> EXEC.
- EXEC (SETTLE cycles):
  - bus_oe=0, alu_en=001, alu_op=op held.
  - Internal counter counts down from SETTLE-1.
  - On the count-0 cycle, register alu_result into rsp_data, then -> RESP.
- RESP: rsp_valid=1, with rsp_id/rsp_data/rsp_err stable until rsp_valid & rsp_ready; that cycle -> IDLE; rsp_valid falls next cycle.
- Output stability: alu_op is held from LOAD_A through EXEC. alu_en=000 and bus_oe=0 in IDLE and RESP.
- No new request is accepted while not IDLE; the requester holds valid and payload until ready.
- Latency (request accepted at cycle T, SETTLE=1):
  - Normal op: LOAD_A T+1, LOAD_B T+2, EXEC T+3, rsp_valid T+4.
  - NOT: rsp_valid T+3.
  - Illegal opcode: rsp_valid T+1.
- Back-to-back throughput: with rsp_ready tied 1, the next grant occurs in the cycle after the RESP handshake.

Optional Feature:
- Macro ALU_SEQ_STATS_EN.
- Defined:
  - Adds output ports op_count (16) and err_count (16).
  - Each increments by 1 on the RESP handshake (err_count when rsp_err=1, otherwise op_count).
  - Both saturate at 16'hFFFF and are cleared by rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then req0 op=0001 a=16'h0003 b=16'h0004, rsp_ready=1:
  - LOAD_A at T+1 with alu_en=100 and bus=0003.
  - LOAD_B at T+2 with alu_en=010 and bus=0004.
  - EXEC at T+3 with alu_en=001.
  - rsp_valid at T+4 with rsp_data=0007, rsp_id=0, rsp_err=0 (bench ALU model).
- req1 op=0111 a=16'h00FF: LOAD_B skipped; rsp_valid at T+3 with rsp_data=FF00, rsp_id=1.
- req0 and req1 both valid continuously with ops 0010 and 0011: grants alternate 0,1,0,1 and each req_ready pulses for exactly one cycle.
- req0 op=1111: rsp_valid at T+1 with rsp_err=1, rsp_data=0; alu_en stays 000 throughout.
- rsp_ready held 0 for 5 cycles during RESP: rsp_valid/rsp_data stay stable, req1_ready stays 0 and alu_en stays 000; release -> IDLE.
- rst asserted during LOAD_B: next cycle all outputs 0 and state IDLE; after release, both requests pending -> req0 granted first.
